dram_resp: RTL
==============

DRAM_RESP -- requirements
Module: dram_resp

Interface
REQ-001 Parameter DEPTH_LOG2, default 10: word-address width; the array holds 2**DEPTH_LOG2 32-bit words.
REQ-002 Parameter WAIT_CYCLES, default 2, range 1-15: extra response wait states; used only with DRAM_WAIT_EN.
REQ-003 clk  input  1: single clock; all state updates on posedge.
REQ-004 rst  input  1: synchronous reset, active-high.
REQ-005 req_valid  input  1: MEM stage presents a load/store request.
REQ-006 req_we  input  1: 1 = store, 0 = load.
REQ-007 req_addr  input  32: byte address.
REQ-008 req_wdata  input  32: store data, right-aligned.
REQ-009 req_size  input  2: 00 byte, 01 half, 10 word; 11 treated as word.
REQ-010 req_unsigned  input  1: zero-extend load result when 1, sign-extend when 0.
REQ-011 resp_valid  output  1: one-cycle pulse; response for accepted request.
REQ-012 resp_rdata  output  32: extended load data; 0 for stores and faults.
REQ-013 resp_misalign  output  1: qualifies resp_valid; request was misaligned.
REQ-014 stall  output  1: MEM stage shall hold its request and freeze upstream stages.

Function
REQ-015 Word index SHALL be req_addr[DEPTH_LOG2+1:2]; higher address bits are ignored (wrap-around).
REQ-016 Misaligned: half with addr[0]=1, or word with addr[1:0]!=00; no array write, resp_rdata=0, resp_misalign=1.
REQ-017 Store byte enables derive from size and addr[1:0]; wdata lanes replicated to the addressed bytes; unaddressed bytes unchanged.
REQ-018 Load selects the addressed byte/half from the word and extends per req_unsigned to 32 bits.
REQ-019 FSM states IDLE, WAIT, RESP; IDLE accepts when req_valid=1 (accept cycle).
REQ-020 IDLE->RESP on accept when WAIT_CYCLES path disabled; IDLE->WAIT on accept with DRAM_WAIT_EN.
REQ-021 WAIT: 4-bit counter loaded with WAIT_CYCLES-1 at accept, decrements each cycle; WAIT->RESP when counter reaches 0.
REQ-022 RESP: resp_valid=1 for exactly one cycle; next state IDLE; a request present in RESP is not accepted until IDLE.
REQ-023 Request fields SHALL be captured into registers at accept; later input changes do not affect the pending transaction.
REQ-024 Store array write occurs at the clock edge leaving the final WAIT cycle (or at accept without DRAM_WAIT_EN); exactly once per store.
REQ-025 A load to the word stored by the immediately preceding store SHALL return the new data.
REQ-026 resp_rdata, resp_misalign are registered and hold 0 whenever resp_valid=0.

Reset
REQ-027 On rst: state=IDLE, counter=0, resp_valid=0, resp_rdata=0, resp_misalign=0, captured request cleared.
REQ-028 Reset mid-transaction (WAIT) SHALL discard the pending request; an uncommitted store SHALL NOT write the array.
REQ-029 Array contents are not reset.
REQ-030 rst has priority over accept in the same cycle.

Configuration
REQ-031 Macro DRAM_WAIT_EN defined: WAIT state and counter present; stall = (state==IDLE && req_valid) || state==WAIT; latency accept-to-resp_valid = WAIT_CYCLES+1.
REQ-032 DRAM_WAIT_EN undefined: no WAIT state/counter; stall tied 0; latency 1 cycle; back-to-back requests accepted every cycle (RESP and IDLE accept merge: accept allowed while resp_valid=1).

Structure
REQ-033 Size encodings (SZ_B, SZ_H, SZ_W) and FSM state encodings SHALL reside in the shared defines header alongside the existing pipeline constants.
REQ-034 Sub-module dram_array: single-port word RAM, 4 byte enables, synchronous write, asynchronous read.
REQ-035 dram_resp owns FSM, alignment check, lane steering, extension.

Verification
REQ-036 Store word 0xDEADBEEF @0x10, then load word @0x10 -> resp_rdata=0xDEADBEEF, resp_misalign=0.
REQ-037 Store byte 0x80 @0x13, load byte signed @0x13 -> 0xFFFFFF80; unsigned -> 0x00000080; load word @0x10 -> 0x80ADBEEF.
REQ-038 Load half @0x11 -> resp_valid=1, resp_misalign=1, resp_rdata=0, array unchanged.
REQ-039 DRAM_WAIT_EN, WAIT_CYCLES=2: req_valid at cycle 0 -> stall high cycles 0-2, resp_valid only at cycle 3.
REQ-040 DRAM_WAIT_EN: store accepted, rst asserted in WAIT -> state IDLE next cycle, no resp_valid, subsequent load returns old data.
REQ-041 Address wrap: store word 0x1234 @ (1<<(DEPTH_LOG2+2)) -> load word @0x0 returns 0x00001234.

Source files
------------

// File: rtl/dram_resp_pkg.sv
// Shared pipeline constants plus the DRAM response-path encodings and the
// lane/alignment helpers used by dram_resp.
package dram_resp_pkg;

    localparam int XLEN  = 32;
    localparam int LANES = XLEN / 8;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } dram_state_e;

    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic [1:0]      size;
        logic            is_unsigned;
    } dram_req_t;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            SZ_B:    mis = 1'b0;
            SZ_H:    mis = addr_lo[0];
            default: mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

    function automatic logic [LANES-1:0] byte_en(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [LANES-1:0] be;
        case (size)
            SZ_B:    be = 4'b0001 << addr_lo;
            SZ_H:    be = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data arrives right-aligned; replicate it so every candidate lane carries it.
    function automatic logic [XLEN-1:0] lane_wdata(input logic [XLEN-1:0] wdata, input logic [1:0] size);
        logic [XLEN-1:0] w;
        case (size)
            SZ_B:    w = {4{wdata[7:0]}};
            SZ_H:    w = {2{wdata[15:0]}};
            default: w = wdata;
        endcase
        return w;
    endfunction

    function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] word,
                                                    input logic [1:0]      size,
                                                    input logic [1:0]      addr_lo,
                                                    input logic            is_unsigned);
        logic [XLEN-1:0] shifted;
        logic [XLEN-1:0] res;
        shifted = word >> {addr_lo, 3'b000};
        case (size)
            SZ_B: begin
                if (is_unsigned) begin
                    res = {24'h00_0000, shifted[7:0]};
                end else begin
                    res = {{24{shifted[7]}}, shifted[7:0]};
                end
            end
            SZ_H: begin
                if (is_unsigned) begin
                    res = {16'h0000, shifted[15:0]};
                end else begin
                    res = {{16{shifted[15]}}, shifted[15:0]};
                end
            end
            default: res = word;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dram_resp_array.sv
// dram_array: single-port word RAM with per-byte write enables, synchronous
// write and asynchronous read. Contents are deliberately never reset.
module dram_array
    import dram_resp_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [LANES-1:0]      be,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [XLEN-1:0]       wdata,
    output logic [XLEN-1:0]       rdata
);

    logic [XLEN-1:0] mem_q [2**DEPTH_LOG2];

    // Byte-masked write port
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (we && be[i]) begin
                mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/dram_resp.sv
// dram_resp: MEM-stage data memory responder (FSM, alignment, lane steering,
// load extension). Define DRAM_WAIT_EN to add WAIT_CYCLES response wait states.
module dram_resp
    import dram_resp_pkg::*;
#(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_misalign,
    output logic        stall
);

    dram_state_e      state_q, state_d;
    dram_req_t        req_q, req_d;
    dram_req_t        req_in_s;
    dram_req_t        cur_s;
    logic             resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]  resp_rdata_q, resp_rdata_d;
    logic             resp_misalign_q, resp_misalign_d;
    logic             accept_s;
    logic             commit_s;
    logic             mis_s;
    logic             mem_we_s;
    logic [LANES-1:0] be_s;
    logic [XLEN-1:0]  mem_wdata_s;
    logic [XLEN-1:0]  mem_rdata_s;
    logic             unused_s;

    assign req_in_s = '{we: req_we, addr: req_addr, wdata: req_wdata,
                        size: req_size, is_unsigned: req_unsigned};

`ifdef DRAM_WAIT_EN
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES - 1);

    logic [3:0] cnt_q, cnt_d;

    // The pending transaction is served from the captured copy; commit is the last WAIT cycle.
    assign accept_s = (state_q == ST_IDLE) && req_valid && !rst;
    assign commit_s = (state_q == ST_WAIT) && (cnt_q == 4'd0) && !rst;
    assign cur_s    = req_q;
    assign stall    = ((state_q == ST_IDLE) && req_valid) || (state_q == ST_WAIT);
    assign unused_s = ^{cur_s.addr[31:DEPTH_LOG2+2]};

    // Next-state, wait counter and request capture
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_WAIT;
                    cnt_d   = WAIT_INIT;
                    req_d   = req_in_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Wait-state counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    // Zero-wait: the request is served in its accept cycle, so RESP and IDLE both accept.
    assign accept_s = req_valid && !rst;
    assign commit_s = accept_s;
    assign cur_s    = req_in_s;
    assign stall    = 1'b0;
    assign unused_s = ^{req_q, cur_s.addr[31:DEPTH_LOG2+2], 4'(WAIT_CYCLES)};

    // Next-state and request capture
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (accept_s) begin
                    state_d = ST_RESP;
                    req_d   = req_in_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end
`endif

    assign mis_s       = is_misaligned(cur_s.size, cur_s.addr[1:0]);
    assign be_s        = byte_en(cur_s.size, cur_s.addr[1:0]);
    assign mem_wdata_s = lane_wdata(cur_s.wdata, cur_s.size);
    assign mem_we_s    = commit_s && cur_s.we && !mis_s;

    // Response payload: zero unless a load or a misalignment is being reported
    always_comb begin
        resp_valid_d    = commit_s;
        resp_rdata_d    = 32'h0000_0000;
        resp_misalign_d = 1'b0;
        if (commit_s && mis_s) begin
            resp_misalign_d = 1'b1;
        end else if (commit_s && !cur_s.we) begin
            resp_rdata_d = load_extend(mem_rdata_s, cur_s.size, cur_s.addr[1:0], cur_s.is_unsigned);
        end else begin
            resp_rdata_d    = 32'h0000_0000;
            resp_misalign_d = 1'b0;
        end
    end

    // State, captured request and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            req_q           <= '0;
            resp_valid_q    <= 1'b0;
            resp_rdata_q    <= 32'h0000_0000;
            resp_misalign_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            req_q           <= req_d;
            resp_valid_q    <= resp_valid_d;
            resp_rdata_q    <= resp_rdata_d;
            resp_misalign_q <= resp_misalign_d;
        end
    end

    assign resp_valid    = resp_valid_q;
    assign resp_rdata    = resp_rdata_q;
    assign resp_misalign = resp_misalign_q;

    dram_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .we    (mem_we_s),
        .be    (be_s),
        .addr  (cur_s.addr[DEPTH_LOG2+1:2]),
        .wdata (mem_wdata_s),
        .rdata (mem_rdata_s)
    );

endmodule
